// File: rtl/adder8_core.sv
// 8-bit ripple-carry adder for a Tiny-Tapeout-style harness, with carry/overflow flags and a sticky carry bit.
// Optional macro ADDER8_PIPE_EN registers uo_out/cout/ovf (1-cycle latency); default is a combinational sum path.
module adder8_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] ui_in,
    input  logic [WIDTH-1:0] uio_in,
    output logic [WIDTH-1:0] uo_out,
    output logic [WIDTH-1:0] uio_out,
    output logic [WIDTH-1:0] uio_oe,
    output logic             cout,
    output logic             ovf,
    output logic             carry_seen
);

    logic [WIDTH:0]   carry_c;
    logic [WIDTH-1:0] sum_c;
    logic             cout_c;
    logic             ovf_c;

    // Explicit full-adder chain; carry into cell 0 is tied low.
    assign carry_c[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum_c[i]       = ui_in[i] ^ uio_in[i] ^ carry_c[i];
        assign carry_c[i + 1] = (ui_in[i] & uio_in[i]) | (carry_c[i] & (ui_in[i] ^ uio_in[i]));
    end

    assign cout_c = carry_c[WIDTH];
    // Signed overflow: carry into the MSB disagrees with carry out of it.
    assign ovf_c  = carry_c[WIDTH-1] ^ carry_c[WIDTH];

`ifdef ADDER8_PIPE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            uo_out <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (ena) begin
            uo_out <= sum_c;
            cout   <= cout_c;
            ovf    <= ovf_c;
        end
    end
`else
    assign uo_out = sum_c;
    assign cout   = cout_c;
    assign ovf    = ovf_c;
`endif

    // Bidirectional pins are permanently inputs.
    assign uio_out = '0;
    assign uio_oe  = '0;

    // Sticky carry; reset takes priority over a same-edge carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_seen <= 1'b0;
        end else if (ena && cout) begin
            carry_seen <= 1'b1;
        end
    end

endmodule

// File: tb/tb_adder8_core.sv
// Directed and exhaustive self-checking bench for adder8_core (default combinational build).
module tb_adder8_core;

    logic       clk;
    logic       clk_en;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       cout;
    logic       ovf;
    logic       carry_seen;

    int unsigned n_checks;
    int unsigned n_pass;

    adder8_core #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .ui_in      (ui_in),
        .uio_in     (uio_in),
        .uo_out     (uo_out),
        .uio_out    (uio_out),
        .uio_oe     (uio_oe),
        .cout       (cout),
        .ovf        (ovf),
        .carry_seen (carry_seen)
    );

    // Clock held still until clk_en so the first check sees no edges at all.
    always #5 if (clk_en) clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        ui_in  = a;
        uio_in = b;
        #1;
    endtask

    task automatic check_sum(input string tag, input logic [7:0] s, input logic c, input logic v);
        check({tag, ".sum"},  16'(uo_out), 16'(s));
        check({tag, ".cout"}, 16'(cout),   16'(c));
        check({tag, ".ovf"},  16'(ovf),    16'(v));
    endtask

    initial begin
        logic [8:0] full;
        logic       exp_ovf;

        n_checks = 0;
        n_pass   = 0;
        clk      = 1'b0;
        clk_en   = 1'b0;
        rst      = 1'b1;
        ena      = 1'b0;

        // Combinational path with no clock edges.
        ui_in  = 8'd12;
        uio_in = 8'd7;
        #10;
        check_sum("12+7", 8'd19, 1'b0, 1'b0);
        check("tie_uio_out_rst", 16'(uio_out), 16'h0);
        check("tie_uio_oe_rst",  16'(uio_oe),  16'h0);

        clk_en = 1'b1;
        @(posedge clk);
        #1;
        check("reset_carry_seen", 16'(carry_seen), 16'h0);

        @(negedge clk);
        rst = 1'b0;
        ena = 1'b1;

        apply(8'd240, 8'd15);
        check_sum("240+15", 8'd255, 1'b0, 1'b0);
        apply(8'd170, 8'd85);
        check_sum("170+85", 8'd255, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("no_carry_yet", 16'(carry_seen), 16'h0);

        apply(8'd255, 8'd1);
        check_sum("255+1", 8'd0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("carry_set", 16'(carry_seen), 16'h1);

        apply(8'd1, 8'd1);
        check_sum("1+1", 8'd2, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("carry_sticky", 16'(carry_seen), 16'h1);

        apply(8'd127, 8'd1);
        check_sum("127+1", 8'd128, 1'b0, 1'b1);
        apply(8'd128, 8'd128);
        check_sum("128+128", 8'd0, 1'b1, 1'b1);

        // Reset wins over a same-edge carry; sum stays live during reset.
        apply(8'd255, 8'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_clears", 16'(carry_seen), 16'h0);
        check_sum("255+1_in_rst", 8'd0, 1'b1, 1'b0);
        check("tie_uio_out_rst2", 16'(uio_out), 16'h0);

        @(negedge clk);
        rst = 1'b0;
        ena = 1'b0;
        @(posedge clk);
        #1;
        check("ena0_hold", 16'(carry_seen), 16'h0);
        check_sum("255+1_ena0", 8'd0, 1'b1, 1'b0);

        // Exhaustive operand sweep against an arithmetic model.
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                ui_in  = 8'(a);
                uio_in = 8'(b);
                #1;
                full    = 9'(a) + 9'(b);
                exp_ovf = (ui_in[7] == uio_in[7]) && (full[7] != ui_in[7]);
                check("sweep_sum", 16'({cout, uo_out}), 16'(full));
                check("sweep_ovf", 16'(ovf), 16'(exp_ovf));
                check("sweep_uio", 16'({uio_out, uio_oe}), 16'h0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adder8_core.md
Name: adder8_core

Overview:
- 8-bit parallel (ripple-carry) adder block for a Tiny-Tapeout-style harness.
- Adds operand A (ui_in) and operand B (uio_in); drives the 8-bit sum on uo_out combinationally.
- Exports carry-out and signed-overflow flags, plus one registered sticky-carry status bit.
- Bidirectional pins are permanently inputs; the block never drives them.

Parameters:
- WIDTH, 8, operand/sum width; only 8 is supported by the pinout.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- rst  input  1  synchronous reset, active-high.
- ena  input  1  harness enable; gates register updates only.
- ui_in  input  8  operand A, unsigned.
- uio_in  input  8  operand B, unsigned.
- uo_out  output  8  sum (A+B) mod 256.
- uio_out  output  8  constant 8'h00.
- uio_oe  output  8  constant 8'h00; all bidirectional pins are inputs.
- cout  output  1  carry out of bit 7.
- ovf  output  1  two's-complement overflow: carry into bit 7 XOR carry out of bit 7.
- carry_seen  output  1  sticky flag, set when cout was 1 on any enabled clock edge.

Behaviour:
- Adder structure: explicit chain of 8 full-adder cells, carry-in of cell 0 tied to 0.
  - s[i] = a[i]^b[i]^c[i].
  - c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]).
- uo_out, cout and ovf are purely combinational.
  - Zero clock latency.
  - Valid after settling, with no clock edge required.
  - Independent of clk, rst and ena.
- Arithmetic: {cout, uo_out} = ui_in + uio_in (9-bit result). Wrap-around is mod 256: 255+1 gives uo_out=0, cout=1.
- ovf: set when operands have equal sign bits and the sum's sign differs. Examples: 127+1 gives ovf=1; 255+1 gives ovf=0.
- carry_seen register, evaluated each rising clk edge in priority order:
  - rst=1: carry_seen <= 0.
  - else ena=1 and cout=1: carry_seen <= 1.
  - else: hold.
- Reset value: carry_seen=0. All other outputs are combinational or constant, so reset has no effect on them.
- Reset mid-operation: the sum stays valid throughout. carry_seen clears on the edge where rst=1, even if cout=1 on that same edge (reset wins).
- ena=0: carry_seen holds; the sum path is still live.
- uio_out and uio_oe: tied to zero at all times, including during reset.

Optional Feature:
- Macro ADDER8_PIPE_EN.
- Defined: uo_out, cout and ovf come from output registers.
  - Registers load the combinational results on each rising edge with ena=1; they hold when ena=0.
  - Latency is exactly 1 clock.
  - rst=1 clears these registers to 0 synchronously.
  - carry_seen samples the registered cout, so it lags 1 further cycle.
- Undefined (default): fully combinational sum path as described above; no output registers are instantiated.

Test Plan:
- ui_in=12, uio_in=7, no clock edges, wait 10 time units -> uo_out=19, cout=0, ovf=0.
- ui_in=240, uio_in=15 -> uo_out=255, cout=0; then ui_in=170, uio_in=85 -> uo_out=255, cout=0, ovf=0.
- ui_in=255, uio_in=1 -> uo_out=0, cout=1, ovf=0; one clk edge with ena=1 -> carry_seen=1; later operands 1+1 -> carry_seen stays 1.
- ui_in=127, uio_in=1 -> uo_out=128, ovf=1, cout=0; ui_in=128, uio_in=128 -> uo_out=0, cout=1, ovf=1.
- carry_seen=1, rst=1 for one edge while 255+1 is applied -> carry_seen=0 after the edge; ena=0 with 255+1 on a following edge -> carry_seen stays 0.
- Random/exhaustive sweep of all 65536 operand pairs -> {cout,uo_out} equals the 9-bit sum, and uio_out=uio_oe=0 in every case. With ADDER8_PIPE_EN the same check applies with 1-cycle latency.
